// File: rtl/a25_copro_master.sv
// a25_copro_master: bridges a valid/ready host request channel onto the A25 CP15
// coprocessor port, issuing one MRC or MCR per request and returning a response.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   i_req_valid/o_req_ready, i_req_write, i_req_crn, i_req_wdata
//                        host request (write=1 -> MCR, write=0 -> MRC)
//   o_rsp_valid/i_rsp_ready, o_rsp_rdata, o_rsp_error
//                        host response, held until accepted
//   i_core_stall         CP15 only samples the operation while this is low
//   o_copro_*            CP15 operation bus (opcode1/2, crm fixed 0, num fixed 15)
//   i_copro_read_data    CP15 registered read data, valid the cycle after the MRC
module a25_copro_master (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [3:0]  i_req_crn,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_error,
    input  logic        i_core_stall,
    output logic [1:0]  o_copro_operation,
    output logic [3:0]  o_copro_crn,
    output logic [31:0] o_copro_write_data,
    output logic [2:0]  o_copro_opcode1,
    output logic [2:0]  o_copro_opcode2,
    output logic [3:0]  o_copro_crm,
    output logic [3:0]  o_copro_num,
    input  logic [31:0] i_copro_read_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic        wr_q;
    logic [3:0]  crn_q;
    logic [31:0] wdata_q;
    logic        bad_wr;

    // Only CP15 registers 1..5 are writable; anything else is rejected without an MCR.
    assign bad_wr = i_req_write && (i_req_crn == 4'd0 || i_req_crn > 4'd5);

    assign o_copro_opcode1 = 3'd0;
    assign o_copro_opcode2 = 3'd0;
    assign o_copro_crm     = 4'd0;
    assign o_copro_num     = 4'd15;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        o_req_ready        = 1'b0;
        o_rsp_valid        = 1'b0;
        o_copro_operation  = 2'd0;
        o_copro_crn        = 4'd0;
        o_copro_write_data = 32'd0;
        case (state)
            IDLE: begin
                // The state is already IDLE while reset is held, so ready is masked.
                o_req_ready = !reset;
                if (i_req_valid)
                    state_nxt = bad_wr ? RESP : ISSUE;
            end
            ISSUE: begin
                o_copro_operation  = wr_q ? 2'd2 : 2'd1;
                o_copro_crn        = crn_q;
                o_copro_write_data = wr_q ? wdata_q : 32'd0;
                if (!i_core_stall)
                    state_nxt = wr_q ? RESP : RDWAIT;
            end
            RDWAIT: begin
                o_copro_crn = crn_q;
                state_nxt   = RESP;
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response fields are set at acceptance (zero data, error for a rejected write)
    // and only overwritten by the MRC capture, so they stay stable through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q        <= 1'b0;
            crn_q       <= 4'd0;
            wdata_q     <= 32'd0;
            o_rsp_rdata <= 32'd0;
            o_rsp_error <= 1'b0;
        end else if (state == IDLE && i_req_valid) begin
            wr_q        <= i_req_write;
            crn_q       <= i_req_crn;
            wdata_q     <= i_req_wdata;
            o_rsp_rdata <= 32'd0;
            o_rsp_error <= bad_wr;
        end else if (state == RDWAIT) begin
            o_rsp_rdata <= i_copro_read_data;
            o_rsp_error <= 1'b0;
        end
    end
endmodule

// File: tb/tb_a25_copro_master.sv
// tb_a25_copro_master: table-driven checks of a25_copro_master against a small CP15 model.
module tb_a25_copro_master;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_write = 1'b0;
    logic [3:0]  i_req_crn = 4'd0;
    logic [31:0] i_req_wdata = 32'd0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_error;
    logic        i_core_stall = 1'b0;
    logic [1:0]  o_copro_operation;
    logic [3:0]  o_copro_crn;
    logic [31:0] o_copro_write_data;
    logic [2:0]  o_copro_opcode1;
    logic [2:0]  o_copro_opcode2;
    logic [3:0]  o_copro_crm;
    logic [3:0]  o_copro_num;
    logic [31:0] i_copro_read_data = 32'd0;

    int pass_cnt = 0;
    int total_cnt = 0;
    int mrc_cnt = 0;
    int mcr_cnt = 0;
    logic [31:0] cp15 [16];

    typedef struct {
        logic        wr;
        logic [3:0]  crn;
        logic [31:0] wd;
        int          stall;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          ops;
    } vec_t;

    vec_t vecs [12];

    a25_copro_master dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_write(i_req_write), .i_req_crn(i_req_crn), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_error(o_rsp_error),
        .i_core_stall(i_core_stall),
        .o_copro_operation(o_copro_operation), .o_copro_crn(o_copro_crn),
        .o_copro_write_data(o_copro_write_data),
        .o_copro_opcode1(o_copro_opcode1), .o_copro_opcode2(o_copro_opcode2),
        .o_copro_crm(o_copro_crm), .o_copro_num(o_copro_num),
        .i_copro_read_data(i_copro_read_data)
    );

    always #5 clk = ~clk;

    // CP15 model: samples the operation only when unstalled, registered read data.
    initial begin
        for (int i = 0; i < 16; i++) cp15[i] = 32'd0;
        cp15[0] = 32'h41560300;
    end

    always @(posedge clk) begin
        if (!i_core_stall) begin
            if (o_copro_operation == 2'd1) begin
                i_copro_read_data <= cp15[o_copro_crn];
                mrc_cnt <= mrc_cnt + 1;
            end else if (o_copro_operation == 2'd2) begin
                cp15[o_copro_crn] <= o_copro_write_data;
                mcr_cnt <= mcr_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_idle_zero(input string name);
        check({name, "_ready"}, {31'd0, o_req_ready}, 32'd0);
        check({name, "_rsp_valid"}, {31'd0, o_rsp_valid}, 32'd0);
        check({name, "_rdata"}, o_rsp_rdata, 32'd0);
        check({name, "_error"}, {31'd0, o_rsp_error}, 32'd0);
        check({name, "_op"}, {30'd0, o_copro_operation}, 32'd0);
        check({name, "_crn"}, {28'd0, o_copro_crn}, 32'd0);
        check({name, "_wdata"}, o_copro_write_data, 32'd0);
    endtask

    task automatic apply(input vec_t v, input string name);
        int seen;
        int lat;
        int ops0;
        logic [31:0] rd;
        logic err;
        seen = 0;
        @(negedge clk);
        check({name, "_ready"}, {31'd0, o_req_ready}, 32'd1);
        i_req_valid = 1'b1;
        i_req_write = v.wr;
        i_req_crn   = v.crn;
        i_req_wdata = v.wd;
        ops0 = mrc_cnt + mcr_cnt;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (o_copro_operation != 2'd0) begin
                check({name, "_op"}, {30'd0, o_copro_operation}, v.wr ? 32'd2 : 32'd1);
                check({name, "_crn"}, {28'd0, o_copro_crn}, {28'd0, v.crn});
                check({name, "_wd"}, o_copro_write_data, v.wr ? v.wd : 32'd0);
                i_core_stall = (seen < v.stall);
                seen++;
            end else begin
                i_core_stall = 1'b0;
            end
        end while (!o_rsp_valid && lat < 20);
        rd  = o_rsp_rdata;
        err = o_rsp_error;
        check({name, "_rdata"}, rd, v.rd);
        check({name, "_error"}, {31'd0, err}, {31'd0, v.err});
        check({name, "_latency"}, lat, v.lat);
        check({name, "_ops"}, (mrc_cnt + mcr_cnt) - ops0, v.ops);
        i_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        i_rsp_ready = 1'b0;
        i_core_stall = 1'b0;
    endtask

    initial begin
        int n;
        int mcr0;
        vecs[0]  = '{1'b0, 4'd0,  32'h0,        0, 32'h41560300, 1'b0, 3, 1};
        vecs[1]  = '{1'b1, 4'd3,  32'hFFFF0001, 0, 32'h0,        1'b0, 2, 1};
        vecs[2]  = '{1'b0, 4'd3,  32'h0,        0, 32'hFFFF0001, 1'b0, 3, 1};
        vecs[3]  = '{1'b1, 4'd2,  32'h5,        3, 32'h0,        1'b0, 5, 1};
        vecs[4]  = '{1'b0, 4'd2,  32'h0,        0, 32'h5,        1'b0, 3, 1};
        vecs[5]  = '{1'b1, 4'd7,  32'h77,       0, 32'h0,        1'b1, 1, 0};
        vecs[6]  = '{1'b1, 4'd0,  32'h99,       0, 32'h0,        1'b1, 1, 0};
        vecs[7]  = '{1'b1, 4'd1,  32'hAAAA5555, 0, 32'h0,        1'b0, 2, 1};
        vecs[8]  = '{1'b1, 4'd5,  32'h12345678, 0, 32'h0,        1'b0, 2, 1};
        vecs[9]  = '{1'b0, 4'd5,  32'h0,        2, 32'h12345678, 1'b0, 5, 1};
        vecs[10] = '{1'b1, 4'd6,  32'h66,       0, 32'h0,        1'b1, 1, 0};
        vecs[11] = '{1'b0, 4'd15, 32'h0,        0, 32'h0,        1'b0, 3, 1};

        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_ready", {31'd0, o_req_ready}, 32'd1);
        check("const_num", {28'd0, o_copro_num}, 32'd15);
        check("const_crm_opc", {22'd0, o_copro_crm, o_copro_opcode1, o_copro_opcode2}, 32'd0);

        for (int i = 0; i < 12; i++)
            apply(vecs[i], $sformatf("v%0d", i));

        // Response held while the host back-pressures, pending request not taken early.
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_write = 1'b0;
        i_req_crn   = 4'd3;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_rsp_valid && n < 20);
        check("hold_latency", n, 3);
        i_req_valid = 1'b1;
        i_req_crn   = 4'd2;
        for (int k = 0; k < 4; k++) begin
            check("hold_valid", {31'd0, o_rsp_valid}, 32'd1);
            check("hold_rdata", o_rsp_rdata, 32'hFFFF0001);
            check("hold_error", {31'd0, o_rsp_error}, 32'd0);
            check("hold_ready", {31'd0, o_req_ready}, 32'd0);
            @(negedge clk);
        end
        i_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        i_rsp_ready = 1'b0;
        @(negedge clk);
        check("after_hs_ready", {31'd0, o_req_ready}, 32'd1);
        check("after_hs_op", {30'd0, o_copro_operation}, 32'd0);
        i_req_valid = 1'b0;

        // Reset during RDWAIT aborts without a response.
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_crn   = 4'd9;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        @(negedge clk);
        check("rdw_issue_op", {30'd0, o_copro_operation}, 32'd1);
        @(negedge clk);
        check("rdw_op", {30'd0, o_copro_operation}, 32'd0);
        check("rdw_crn", {28'd0, o_copro_crn}, 32'd9);
        reset = 1'b1;
        #1;
        check_idle_zero("rdw_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rdw_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
        end
        apply(vecs[0], "rdw_reread");

        // Reset during a stalled MCR: the write never reaches CP15.
        @(negedge clk);
        i_req_valid  = 1'b1;
        i_req_write  = 1'b1;
        i_req_crn    = 4'd4;
        i_req_wdata  = 32'hDEAD0000;
        i_core_stall = 1'b1;
        mcr0 = mcr_cnt;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        @(negedge clk);
        check("stall_op", {30'd0, o_copro_operation}, 32'd2);
        @(negedge clk);
        check("stall_hold_wd", o_copro_write_data, 32'hDEAD0000);
        reset = 1'b1;
        #1;
        check("stall_reset_op", {30'd0, o_copro_operation}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        i_core_stall = 1'b0;
        check("stall_no_mcr", mcr_cnt - mcr0, 0);
        apply('{1'b0, 4'd4, 32'h0, 0, 32'h0, 1'b0, 3, 1}, "stall_reread");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
